// File: rtl/stopwatch_cmd_ctrl.sv
// Stopwatch command/timebase controller: button sync + debounce, start/stop/reset FSM, 1 s prescaler.
// Optional macro STOPWATCH_AUTO_STOP_EN adds run_limit_hit to freeze the display at 255:59.
module stopwatch_cmd_ctrl #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_start,
    input  logic                        btn_stop,
    input  logic                        btn_reset,
`ifdef STOPWATCH_AUTO_STOP_EN
    input  logic                        run_limit_hit,
`endif
    output logic                        count_en,
    output logic                        clear_counters,
    output logic [1:0]                  status,
    output logic [$clog2(TICK_DIV)-1:0] prescale
);

    localparam int unsigned NBTN = 3;
    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned DCW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PW-1:0]  TERM     = PW'(TICK_DIV - 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam int unsigned B_START = 0;
    localparam int unsigned B_STOP  = 1;
    localparam int unsigned B_RESET = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              ce_q, ce_d;
    logic              clr_q, clr_d;
    logic [NBTN-1:0]   sync1_q, sync2_q;
    logic [NBTN-1:0]   stable_q, stable_d;
    logic [NBTN-1:0]   evt_q, evt_d;
    logic [DCW-1:0]    cnt_q [NBTN];
    logic [DCW-1:0]    cnt_d [NBTN];
    logic [NBTN-1:0]   btn_raw;
    logic              limit_c;
    logic              start_ok_c;

    assign btn_raw = {btn_reset, btn_stop, btn_start};

`ifdef STOPWATCH_AUTO_STOP_EN
    assign limit_c = run_limit_hit;
`else
    assign limit_c = 1'b0;
`endif

    assign start_ok_c = evt_q[B_START] & ~limit_c;

    // Debounce: a level change is accepted after DEB_CYCLES consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < NBTN; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            evt_d[i]    = 1'b0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    evt_d[i]    = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    // Command FSM and prescaler; reset beats stop beats start.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ce_d    = 1'b0;
        clr_d   = 1'b0;
        if (evt_q[B_RESET]) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (evt_q[B_STOP]) begin
                        state_d = ST_PAUSED;
                    end else if (pre_q == TERM) begin
                        // At the run limit the terminal count freezes instead of ticking.
                        if (limit_c) begin
                            state_d = ST_PAUSED;
                        end else begin
                            pre_d = '0;
                            ce_d  = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (start_ok_c) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pre_q    <= '0;
            ce_q     <= 1'b0;
            clr_q    <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            evt_q    <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            ce_q     <= ce_d;
            clr_q    <= clr_d;
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            evt_q    <= evt_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign status         = state_q;
    assign prescale       = pre_q;
    assign count_en       = ce_q;
    assign clear_counters = clr_q;

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Directed bench for stopwatch_cmd_ctrl; expected output events are queued with their cycle.
module tb_stopwatch_cmd_ctrl;

    localparam int EV_ST  = 0;
    localparam int EV_CE  = 1;
    localparam int EV_CLR = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       btn_start, btn_stop, btn_reset;
    logic       count_en, clear_counters;
    logic [1:0] status;
    logic [3:0] prescale;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;
    logic [1:0] prev_status = 2'b00;
    ev_t exp_q[$];

    stopwatch_cmd_ctrl #(.TICK_DIV(10), .DEB_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start      (btn_start),
        .btn_stop       (btn_stop),
        .btn_reset      (btn_reset),
`ifdef STOPWATCH_AUTO_STOP_EN
        .run_limit_hit  (1'b0),
`endif
        .count_en       (count_en),
        .clear_counters (clear_counters),
        .status         (status),
        .prescale       (prescale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input int kind, input int val);
        ev_t e;
        chk("evt_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("evt_kind", 32'(kind * 4 + val), 32'(e.kind * 4 + e.val));
        chk("evt_cycle", 32'(cyc), 32'(e.cyc));
    endtask

    // Output monitor: every status change, count_en and clear pulse must match the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (status !== prev_status) begin
                check_evt(EV_ST, int'(status));
                prev_status = status;
            end
            if (count_en)       check_evt(EV_CE, 0);
            if (clear_counters) check_evt(EV_CLR, 0);
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    int t0, r, s, b, g, u, x, w;

    initial begin
        rst_n = 1'b1;
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_reset = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_count_en", 32'(count_en), 32'd0);
        chk("rst_clear", 32'(clear_counters), 32'd0);
        chk("rst_prescale", 32'(prescale), 32'd0);
        rst_n = 1'b1;
        prev_status = 2'b00;
        mon_en = 1'b1;

        // Start press: RUNNING 7 cycles later, tick every 10 cycles.
        t0 = cyc + 2;
        wait_cyc(t0);
        btn_start = 1'b1;
        push(EV_ST, 1, t0 + 7);
        push(EV_CE, 0, t0 + 17);
        push(EV_CE, 0, t0 + 27);
        push(EV_CE, 0, t0 + 37);
        wait_cyc(t0 + 7);
        chk("run_prescale0", 32'(prescale), 32'd0);
        wait_cyc(t0 + 13);
        chk("run_prescale6", 32'(prescale), 32'd6);
        wait_cyc(t0 + 20);
        btn_start = 1'b0;

        // Stop lands while prescale=6: PAUSED holds 6.
        wait_cyc(t0 + 37);
        btn_stop = 1'b1;
        push(EV_ST, 2, t0 + 44);
        wait_cyc(t0 + 44);
        chk("pause_prescale", 32'(prescale), 32'd6);
        wait_cyc(t0 + 50);
        chk("pause_hold", 32'(prescale), 32'd6);
        btn_stop = 1'b0;

        // Resume: 6 -> 9 then tick 4 cycles after RUNNING returns.
        r = t0 + 52;
        wait_cyc(r);
        btn_start = 1'b1;
        push(EV_ST, 1, r + 7);
        push(EV_CE, 0, r + 11);
        push(EV_CE, 0, r + 21);
        wait_cyc(r + 7);
        chk("resume_prescale6", 32'(prescale), 32'd6);
        wait_cyc(r + 8);
        chk("resume_prescale7", 32'(prescale), 32'd7);
        wait_cyc(r + 10);
        btn_start = 1'b0;

        // All three buttons together: only reset is taken.
        s = r + 20;
        wait_cyc(s);
        btn_start = 1'b1;
        btn_stop  = 1'b1;
        btn_reset = 1'b1;
        push(EV_ST, 0, s + 7);
        push(EV_CLR, 0, s + 7);
        wait_cyc(s + 7);
        chk("simul_prescale", 32'(prescale), 32'd0);
        wait_cyc(s + 10);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_reset = 1'b0;

        // Bouncing start never holds long enough to register.
        b = s + 20;
        wait_cyc(b);
        for (int i = 0; i < 8; i++) begin
            btn_start = ~btn_start;
            repeat (2) @(negedge clk);
        end
        btn_start = 1'b0;
        wait_cyc(b + 30);
        chk("bounce_status", 32'(status), 32'd0);

        // Stop event on the terminal cycle: tick suppressed, prescale held at 9.
        g = b + 30;
        btn_start = 1'b1;
        push(EV_ST, 1, g + 7);
        push(EV_CE, 0, g + 17);
        wait_cyc(g + 12);
        btn_start = 1'b0;
        wait_cyc(g + 20);
        btn_stop = 1'b1;
        push(EV_ST, 2, g + 27);
        wait_cyc(g + 27);
        chk("term_stop_prescale", 32'(prescale), 32'd9);
        wait_cyc(g + 30);
        btn_stop = 1'b0;
        wait_cyc(g + 32);
        chk("term_hold_prescale", 32'(prescale), 32'd9);

        // Resume from 9 ticks one cycle later; reset on a later terminal cycle suppresses the tick.
        u = g + 35;
        wait_cyc(u);
        btn_start = 1'b1;
        push(EV_ST, 1, u + 7);
        push(EV_CE, 0, u + 8);
        wait_cyc(u + 8);
        btn_start = 1'b0;
        wait_cyc(u + 11);
        btn_reset = 1'b1;
        push(EV_ST, 0, u + 18);
        push(EV_CLR, 0, u + 18);
        wait_cyc(u + 18);
        chk("term_reset_prescale", 32'(prescale), 32'd0);
        wait_cyc(u + 21);
        btn_reset = 1'b0;

        // Async reset mid-debounce with button held: press restarts from reset release.
        x = u + 30;
        wait_cyc(x);
        btn_start = 1'b1;
        wait_cyc(x + 3);
        rst_n = 1'b0;
        wait_cyc(x + 5);
        w = cyc;
        rst_n = 1'b1;
        push(EV_ST, 1, w + 7);
        wait_cyc(w + 7);
        chk("held_rst_status", 32'(status), 32'd1);
        chk("held_rst_prescale", 32'(prescale), 32'd0);
        wait_cyc(w + 12);
        btn_start = 1'b0;
        mon_en = 1'b0;

        chk("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
